// File: rtl/rtype_issue_if.sv
// Handshake and ALU/debug bus between the instruction source and rtype_issue.
// The master side feeds instructions and the ALU result; the slave side is the issue stage.
interface rtype_issue_if #(parameter int XLEN = 32);
   logic [31:0]     instr;
   logic            instr_valid;
   logic            instr_ready;
   logic            hold;
   logic [XLEN-1:0] alu_rsdata;
   logic [XLEN-1:0] alu_rtdata;
   logic [5:0]      alu_func;
   logic [XLEN-1:0] alu_result;
   logic [4:0]      dbg_addr;
   logic [XLEN-1:0] dbg_data;
   logic [31:0]     retire_count;
   logic [15:0]     illegal_count;

   modport master (
      output instr, instr_valid, hold, alu_result, dbg_addr,
      input  instr_ready, alu_rsdata, alu_rtdata, alu_func, dbg_data,
             retire_count, illegal_count
   );

   modport slave (
      input  instr, instr_valid, hold, alu_result, dbg_addr,
      output instr_ready, alu_rsdata, alu_rtdata, alu_func, dbg_data,
             retire_count, illegal_count
   );
endinterface

// File: rtl/rtype_issue.sv
// Two-stage (D, EX) R-type issue stage: register file read with one-cycle
// forwarding from EX, operand presentation to the ALU, and write-back.
module rtype_issue #(
   parameter int REG_COUNT = 32,
   parameter int XLEN      = 32
) (
   input logic           clk,
   input logic           resetn,
   rtype_issue_if.slave  bus
);
   localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                          F_OR  = 6'b100101, F_XOR = 6'b100110, F_SLT = 6'b101010,
                          F_MOV = 6'b001010;

   logic [XLEN-1:0] regs_q [REG_COUNT];
   logic [XLEN-1:0] regs_d [REG_COUNT];
   logic [XLEN-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
   logic [5:0]      ex_func_q, ex_func_d;
   logic [4:0]      ex_rd_q, ex_rd_d;
   logic            ex_legal_q, ex_legal_d, ex_valid_q, ex_valid_d;
   logic [31:0]     retire_q, retire_d;
   logic [15:0]     illegal_q, illegal_d;

   logic [4:0]      d_rs, d_rt, d_rd;
   logic [5:0]      d_op, d_func;
   logic            d_legal, accept, ex_wen;
   logic [XLEN-1:0] d_rs_val, d_rt_val;
   logic            unused_shamt;

   assign d_op         = bus.instr[31:26];
   assign d_rs         = bus.instr[25:21];
   assign d_rt         = bus.instr[20:16];
   assign d_rd         = bus.instr[15:11];
   assign d_func       = bus.instr[5:0];
   assign unused_shamt = ^bus.instr[10:6];

   assign d_legal = (d_op == 6'd0) &&
                    (d_func inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT, F_MOV});
   assign accept  = bus.instr_valid & ~bus.hold;
   assign ex_wen  = ex_valid_q & ex_legal_q & ~bus.hold & (ex_rd_q != 5'd0);

   // The EX result lands in the array on this same edge, so D takes it from the ALU.
   always_comb begin
      d_rs_val = regs_q[d_rs];
      d_rt_val = regs_q[d_rt];
      if (ex_wen && ex_rd_q == d_rs) d_rs_val = bus.alu_result;
      if (ex_wen && ex_rd_q == d_rt) d_rt_val = bus.alu_result;
      if (d_rs == 5'd0) d_rs_val = '0;
      if (d_rt == 5'd0) d_rt_val = '0;
   end

   always_comb begin
      regs_d     = regs_q;
      ex_rs_d    = ex_rs_q;
      ex_rt_d    = ex_rt_q;
      ex_func_d  = ex_func_q;
      ex_rd_d    = ex_rd_q;
      ex_legal_d = ex_legal_q;
      ex_valid_d = ex_valid_q;
      retire_d   = retire_q;
      illegal_d  = illegal_q;
      if (!bus.hold) begin
         ex_valid_d = accept;
         if (accept) begin
            ex_rs_d    = d_rs_val;
            ex_rt_d    = d_rt_val;
            ex_func_d  = d_func;
            ex_rd_d    = d_rd;
            ex_legal_d = d_legal;
         end
         if (ex_valid_q && ex_legal_q) retire_d = retire_q + 32'd1;
         if (ex_valid_q && !ex_legal_q && illegal_q != 16'hFFFF)
            illegal_d = illegal_q + 16'd1;
      end
      if (ex_wen) regs_d[ex_rd_q] = bus.alu_result;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
         ex_rs_q    <= '0;
         ex_rt_q    <= '0;
         ex_func_q  <= '0;
         ex_rd_q    <= '0;
         ex_legal_q <= 1'b0;
         ex_valid_q <= 1'b0;
         retire_q   <= '0;
         illegal_q  <= '0;
      end else begin
         regs_q     <= regs_d;
         ex_rs_q    <= ex_rs_d;
         ex_rt_q    <= ex_rt_d;
         ex_func_q  <= ex_func_d;
         ex_rd_q    <= ex_rd_d;
         ex_legal_q <= ex_legal_d;
         ex_valid_q <= ex_valid_d;
         retire_q   <= retire_d;
         illegal_q  <= illegal_d;
      end
   end

   assign bus.instr_ready   = ~bus.hold;
   assign bus.alu_rsdata    = ex_rs_q;
   assign bus.alu_rtdata    = ex_rt_q;
   assign bus.alu_func      = (ex_valid_q && ex_legal_q) ? ex_func_q : 6'd0;
   assign bus.dbg_data      = (bus.dbg_addr == 5'd0) ? '0 : regs_q[bus.dbg_addr];
   assign bus.retire_count  = retire_q;
   assign bus.illegal_count = illegal_q;
endmodule

// File: tb/tb_rtype_issue.sv
// Bench for rtype_issue: external ALU model, architectural register model and
// a queue of expected EX-stage func/result pairs checked one cycle after accept.
module tb_rtype_issue;
   localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                          F_OR  = 6'b100101, F_XOR = 6'b100110, F_SLT = 6'b101010,
                          F_MOV = 6'b001010;

   typedef struct {
      logic [5:0]  func;
      logic [31:0] res;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   rtype_issue_if #(.XLEN(32)) bus ();

   rtype_issue #(.REG_COUNT(32), .XLEN(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   exp_t        sb_q[$];
   logic [31:0] m [32];
   logic [31:0] exp_ret = 0;
   logic [15:0] exp_ill = 0;
   logic [31:0] mov_bias = 0;
   logic        chk_pend = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // MOV adds a bench-controlled bias so registers can be seeded from $0.
   function automatic logic [31:0] alu(input logic [5:0] fn, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] bias);
      case (fn)
         F_ADD:   return a + b;
         F_SUB:   return a - b;
         F_AND:   return a & b;
         F_OR:    return a | b;
         F_XOR:   return a ^ b;
         F_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         F_MOV:   return a + bias;
         default: return 32'd0;
      endcase
   endfunction

   always_comb bus.alu_result = alu(bus.alu_func, bus.alu_rsdata, bus.alu_rtdata, mov_bias);

   function automatic logic [31:0] rt_ins(input logic [5:0] op, input int rs, input int rt,
                                          input int rd, input logic [5:0] fn);
      logic [4:0] s, t, d;
      s = 5'(rs); t = 5'(rt); d = 5'(rd);
      return {op, s, t, d, 5'd0, fn};
   endfunction

   always @(posedge clk) chk_pend <= resetn && bus.instr_valid && !bus.hold;

   always @(negedge clk) begin
      if (chk_pend && resetn) begin
         if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("ex_func", 32'(bus.alu_func), 32'(e.func));
            chk("ex_res", bus.alu_result, e.res);
         end
      end
   end

   task automatic issue(input logic [31:0] ins);
      exp_t e;
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd;
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
      if (op == 6'd0 && (fn inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT, F_MOV})) begin
         e.func = fn;
         e.res  = alu(fn, m[rs], m[rt], mov_bias);
         if (rd != 5'd0) m[rd] = e.res;
         exp_ret++;
      end else begin
         e.func = 6'd0;
         e.res  = 32'd0;
         if (exp_ill != 16'hFFFF) exp_ill++;
      end
      sb_q.push_back(e);
      bus.instr = ins;
      bus.instr_valid = 1'b1;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk_reg(input string tag, input int a, input logic [31:0] exp);
      bus.dbg_addr = 5'(a);
      #1;
      chk(tag, bus.dbg_data, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
      exp_ret = 0;
      exp_ill = 0;
      sb_q.delete();
   endtask

   initial begin
      bus.instr = 32'd0;
      bus.instr_valid = 1'b0;
      bus.hold = 1'b0;
      bus.dbg_addr = 5'd0;
      model_reset();
      resetn = 1'b0;
      idle(2);
      chk("ready_in_rst", 32'(bus.instr_ready), 32'd1);
      @(negedge clk); resetn = 1'b1;
      idle(1);

      for (int a = 0; a < 32; a++) chk_reg("rst_reg", a, 32'd0);
      chk("rst_func", 32'(bus.alu_func), 32'd0);
      chk("rst_retire", bus.retire_count, 32'd0);
      chk("rst_illegal", 32'(bus.illegal_count), 32'd0);

      // seed r1 = 5, r2 = r1 + 2 = 7
      mov_bias = 32'd5; issue(rt_ins(6'd0, 0, 0, 1, F_MOV)); idle(1);
      mov_bias = 32'd2; issue(rt_ins(6'd0, 1, 0, 2, F_MOV)); idle(1);
      mov_bias = 32'd0;
      chk_reg("r1_seed", 1, 32'd5);
      chk_reg("r2_seed", 2, 32'd7);
      chk("retire_seed", bus.retire_count, 32'd2);

      issue(rt_ins(6'd0, 1, 2, 3, F_ADD));
      chk_reg("r3_before_wb", 3, 32'd0);
      idle(1);
      chk_reg("r3_add", 3, 32'd12);
      chk("retire_add", bus.retire_count, 32'd3);

      issue(rt_ins(6'd0, 3, 3, 4, F_ADD));
      issue(rt_ins(6'd0, 4, 1, 5, F_SUB));
      idle(1);
      chk_reg("r4_fwd", 4, 32'd24);
      chk_reg("r5_fwd", 5, 32'd19);
      chk("retire_b2b", bus.retire_count, exp_ret);

      issue(rt_ins(6'd0, 1, 2, 0, F_ADD));
      issue(rt_ins(6'd0, 0, 1, 6, F_ADD));
      idle(1);
      chk_reg("r0_zero", 0, 32'd0);
      chk_reg("r6_no_fwd_r0", 6, 32'd5);
      chk("retire_r0", bus.retire_count, 32'd7);

      issue(rt_ins(6'b100011, 1, 2, 9, F_ADD));
      issue(rt_ins(6'd0, 1, 2, 9, 6'd0));
      issue(rt_ins(6'd0, 1, 3, 10, F_SLT));
      idle(1);
      chk_reg("r9_illegal", 9, 32'd0);
      chk_reg("r10_slt", 10, 32'd1);
      chk("illegal_cnt", 32'(bus.illegal_count), 32'd2);
      chk("retire_ill", bus.retire_count, 32'd8);

      // hold with EX full: operands frozen, write deferred to release
      issue(rt_ins(6'd0, 1, 2, 7, F_ADD));
      bus.hold = 1'b1;
      bus.dbg_addr = 5'd7;
      repeat (3) begin
         @(posedge clk); #1;
         chk("hold_rs", bus.alu_rsdata, 32'd5);
         chk("hold_rt", bus.alu_rtdata, 32'd7);
         chk("hold_func", 32'(bus.alu_func), 32'(F_ADD));
         chk("hold_ready", 32'(bus.instr_ready), 32'd0);
         chk("hold_r7", bus.dbg_data, 32'd0);
         chk("hold_retire", bus.retire_count, 32'd8);
      end
      bus.hold = 1'b0;
      idle(1);
      chk_reg("r7_release", 7, 32'd12);
      chk("retire_release", bus.retire_count, 32'd9);

      // reset with an instruction in EX
      issue(rt_ins(6'd0, 1, 1, 8, F_ADD));
      resetn = 1'b0;
      model_reset();
      #1;
      chk("mrst_func", 32'(bus.alu_func), 32'd0);
      chk("mrst_rs", bus.alu_rsdata, 32'd0);
      chk("mrst_rt", bus.alu_rtdata, 32'd0);
      chk("mrst_retire", bus.retire_count, 32'd0);
      chk("mrst_illegal", 32'(bus.illegal_count), 32'd0);
      chk("mrst_ready", 32'(bus.instr_ready), 32'd1);
      idle(1);
      @(negedge clk); resetn = 1'b1;
      idle(1);
      chk_reg("mrst_r8", 8, 32'd0);
      chk_reg("mrst_r3", 3, 32'd0);

      repeat (65535) issue(rt_ins(6'b100011, 0, 0, 1, F_ADD));
      idle(1);
      chk("ill_full", 32'(bus.illegal_count), 32'h0000FFFF);
      repeat (2) issue(rt_ins(6'd0, 0, 0, 1, 6'd0));
      idle(1);
      chk("ill_sat", 32'(bus.illegal_count), 32'h0000FFFF);
      chk("ill_sat_model", 32'(bus.illegal_count), 32'(exp_ill));
      chk_reg("ill_r1", 1, 32'd0);
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
